// File: rtl/fetch_queue.sv
// fetch_queue: parametrised {pc, inst} FIFO between IFU and IDU with a
// valid/ready handshake on both sides, a front-end flush, and an
// illegal-encoding flag for non-32-bit instructions at the head.
// Optional feature macro: FETCHQ_BYPASS_EN (empty-queue passthrough).
module fetch_queue #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [XLEN-1:0]  in_inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [XLEN-1:0]  out_inst_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic   w_empty;
  logic   w_full;
  logic   w_push;
  logic   w_pop;
  logic   w_wr_en;
  logic   w_rd_en;
  entry_t w_in;
  entry_t w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_in       = '{pc: in_pc_i, inst: in_inst_i};

  // A full queue refuses input even if the head leaves this same cycle.
  assign in_ready_o = !w_full;
  assign w_push     = in_valid_i && !w_full;
  assign w_pop      = out_valid_o && out_ready_i;

`ifdef FETCHQ_BYPASS_EN
  // Empty queue forwards the incoming entry; a same-cycle accept skips storage.
  logic w_bypass;
  assign w_bypass    = w_empty && in_valid_i && !flush_i;
  assign out_valid_o = !w_empty || w_bypass;
  assign w_head      = w_empty ? w_in : r_mem[r_rd_ptr];
  assign w_wr_en     = w_push && !(w_empty && out_ready_i);
  assign w_rd_en     = w_pop && !w_empty;
`else
  // Registered-only path: new entries reach the head one edge after write.
  assign out_valid_o = !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_wr_en     = w_push;
  assign w_rd_en     = w_pop;
`endif

  assign out_pc_o      = out_valid_o ? w_head.pc   : '0;
  assign out_inst_o    = out_valid_o ? w_head.inst : '0;
  assign out_illegal_o = out_valid_o && (w_head.inst[1:0] != 2'b11);
  assign count_o       = r_count;

  // Entry storage; not reset, validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_wr_en && !flush_i) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // Pointer and occupancy tracking; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr_en && w_rd_en) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard queue of expected entries,
// one task per scenario with inline comparisons.
module tb_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [XLEN-1:0]  in_pc_i = '0;
  logic [XLEN-1:0]  in_inst_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [XLEN-1:0]  out_pc_o;
  logic [XLEN-1:0]  out_inst_o;
  logic             out_illegal_o;
  logic [CNT_W-1:0] count_o;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_pc_i      (in_pc_i),
    .in_inst_i    (in_inst_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_pc_o     (out_pc_o),
    .out_inst_o   (out_inst_o),
    .out_illegal_o(out_illegal_o),
    .count_o      (count_o)
  );

  // Apply inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic v, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] inst, input logic rdy,
                       input logic fl);
    in_valid_i  = v;
    in_pc_i     = pc;
    in_inst_i   = inst;
    out_ready_i = rdy;
    flush_i     = fl;
    #1;
  endtask

  // Advance the scoreboard model from the driven inputs, then clock the DUT.
  task automatic tick();
    int unsigned sz;
    logic push;
    logic pop;
    ent_t e;
    sz   = sb.size();
    push = in_valid_i && (sz != DEPTH);
    pop  = out_ready_i && (sz != 0);
`ifdef FETCHQ_BYPASS_EN
    if (sz == 0 && in_valid_i && out_ready_i) push = 1'b0;
`endif
    e.pc   = in_pc_i;
    e.inst = in_inst_i;
    if (rst || flush_i) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    n_checks++; if (count_o !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_checks++; if (out_pc_o !== '0 || out_inst_o !== '0) begin n_fail++; $display("FAIL reset_out_data pc=%h inst=%h exp=0", out_pc_o, out_inst_o); end
    n_checks++; if (out_illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", out_illegal_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, XLEN'(i * 4), 32'h0000_0013 | XLEN'(i << 20), 1'b0, 1'b0);
      n_checks++; if (in_ready_o !== (i < 4)) begin n_fail++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready_o, (i < 4)); end
      tick();
      n_checks++; if (count_o !== CNT_W'(sb.size())) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count_o, sb.size()); end
      n_checks++; if (out_pc_o !== 32'h0) begin n_fail++; $display("FAIL fill_head_stable i=%0d got=%h exp=0", i, out_pc_o); end
    end
    n_checks++; if (count_o !== CNT_W'(4) || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full count=%0d ready=%b exp=4/0", count_o, in_ready_o); end
  endtask

  task automatic test_drain_wrap();
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 4; i++) begin
          drive(1'b1, XLEN'(r * 256 + i * 4), 32'h0000_0093, 1'b0, 1'b0);
          tick();
        end
      end
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_valid r=%0d i=%0d got=%b exp=1", r, i, out_valid_o); end
        n_checks++; if (out_pc_o !== XLEN'(r * 256 + i * 4)) begin n_fail++; $display("FAIL drain_pc r=%0d i=%0d got=%h exp=%h", r, i, out_pc_o, r * 256 + i * 4); end
        if (sb.size() != 0) begin
          n_checks++; if (out_inst_o !== sb[0].inst) begin n_fail++; $display("FAIL drain_inst r=%0d i=%0d got=%h exp=%h", r, i, out_inst_o, sb[0].inst); end
        end
        tick();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      n_checks++; if (out_valid_o !== 1'b0 || count_o !== CNT_W'(0) || out_pc_o !== '0) begin n_fail++; $display("FAIL drain_empty r=%0d valid=%b count=%0d pc=%h exp=0/0/0", r, out_valid_o, count_o, out_pc_o); end
    end
  endtask

  task automatic test_simul();
    drive(1'b1, 32'h0, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h4, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8, 32'h0000_0013, 1'b1, 1'b0);
    n_checks++; if (out_pc_o !== 32'h0) begin n_fail++; $display("FAIL simul_head_before got=%h exp=0", out_pc_o); end
    tick();
    n_checks++; if (count_o !== CNT_W'(2)) begin n_fail++; $display("FAIL simul_count got=%0d exp=2", count_o); end
    n_checks++; if (out_pc_o !== 32'h4) begin n_fail++; $display("FAIL simul_head_after got=%h exp=4", out_pc_o); end
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick(); tick();
    n_checks++; if (count_o !== CNT_W'(sb.size())) begin n_fail++; $display("FAIL simul_drain got=%0d exp=%0d", count_o, sb.size()); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, XLEN'(32'h100 + i * 4), 32'h0000_0013, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h20, 32'h0000_0013, 1'b0, 1'b1);
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready_o); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (count_o !== CNT_W'(0) || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty count=%0d valid=%b exp=0/0", count_o, out_valid_o); end
    drive(1'b1, 32'h40, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (out_pc_o !== 32'h40 || count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL flush_after pc=%h count=%0d exp=40/1", out_pc_o, count_o); end
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h200, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h204, 32'h0000_4501, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_illegal_o !== 1'b0) begin n_fail++; $display("FAIL illegal_first got=%b exp=0", out_illegal_o); end
    tick();
    n_checks++; if (out_illegal_o !== 1'b1 || out_inst_o !== 32'h0000_4501) begin n_fail++; $display("FAIL illegal_second ill=%b inst=%h exp=1/00004501", out_illegal_o, out_inst_o); end
    tick();
    n_checks++; if (out_illegal_o !== 1'b0) begin n_fail++; $display("FAIL illegal_empty got=%b exp=0", out_illegal_o); end
  endtask

  task automatic test_latency();
    drive(1'b1, 32'h80, 32'h0000_0013, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
    n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h80) begin n_fail++; $display("FAIL bypass_pass valid=%b pc=%h exp=1/80", out_valid_o, out_pc_o); end
    tick();
    n_checks++; if (count_o !== CNT_W'(0)) begin n_fail++; $display("FAIL bypass_count got=%0d exp=0", count_o); end
    drive(1'b1, 32'h84, 32'h0000_0013, 1'b1, 1'b1);
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bypass_flush_valid got=%b exp=0", out_valid_o); end
    tick();
`else
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL latency_no_comb got=%b exp=0", out_valid_o); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h80 || count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL latency_one valid=%b pc=%h count=%0d exp=1/80/1", out_valid_o, out_pc_o, count_o); end
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h300, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h304, 32'h0000_0013, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (count_o !== CNT_W'(0) || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid count=%0d valid=%b ready=%b exp=0/0/1", count_o, out_valid_o, in_ready_o); end
  endtask

  task automatic test_back_to_back();
    logic exp_valid;
    ent_t exp_head;
    for (int c = 0; c < 300; c++) begin
      drive(1'b1 & 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      exp_valid = (sb.size() != 0);
      exp_head  = (sb.size() != 0) ? sb[0] : '0;
`ifdef FETCHQ_BYPASS_EN
      if (sb.size() == 0 && in_valid_i && !flush_i) begin
        exp_valid = 1'b1;
        exp_head  = '{pc: in_pc_i, inst: in_inst_i};
      end
`endif
      n_checks++; if (in_ready_o !== (sb.size() != DEPTH)) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, in_ready_o, (sb.size() != DEPTH)); end
      n_checks++; if (out_valid_o !== exp_valid) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid_o, exp_valid); end
      n_checks++; if (out_pc_o !== exp_head.pc || out_inst_o !== exp_head.inst) begin n_fail++; $display("FAIL b2b_head c=%0d got=%h/%h exp=%h/%h", c, out_pc_o, out_inst_o, exp_head.pc, exp_head.inst); end
      n_checks++; if (out_illegal_o !== (exp_valid && exp_head.inst[1:0] != 2'b11)) begin n_fail++; $display("FAIL b2b_illegal c=%0d got=%b", c, out_illegal_o); end
      n_checks++; if (count_o !== CNT_W'(sb.size())) begin n_fail++; $display("FAIL b2b_count c=%0d got=%0d exp=%0d", c, count_o, sb.size()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simul();
    test_flush();
    test_illegal();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
